// File: rtl/useq_decoder.sv
// rtl/useq_decoder.sv - microcoded instruction sequencer (optional CALL/RET via USEQ_SUBROUTINE_EN)
module useq_decoder #(
    parameter int IW          = 16,
    parameter int OPC_W       = 6,
    parameter int SHORT_W     = 2,
    parameter int UADDR_W     = 8,
    parameter int UWORD_W     = 48,
    parameter int CTRL_W      = 8,
    parameter int FETCH_UADDR = 2,
    parameter int DISP_BASE   = 0,
    parameter logic [IW-1:0] HALT_INSTR = 16'hfe00
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic [IW-1:0]                        i_instr,
    output logic [UADDR_W-1:0]                   o_ucode_addr,
    input  logic [UWORD_W-1:0]                   i_ucode_data,
    input  logic [3:0]                           i_cond_in,
    input  logic                                 i_mem_ready,
    input  logic                                 i_resume,
    output logic [CTRL_W-1:0]                    o_ctrl,
    output logic [UWORD_W-CTRL_W-UADDR_W-9:0]    o_ufield,
    output logic                                 o_phase,
    output logic                                 o_stall,
    output logic                                 o_halted
);

    // Microword field positions, MSB down
    localparam int CTRL_LSB  = UWORD_W - CTRL_W;
    localparam int NADDR_LSB = CTRL_LSB - UADDR_W;
    localparam int SEQ_LSB   = NADDR_LSB - 3;
    localparam int CEN_BIT   = SEQ_LSB - 1;
    localparam int CSEL_LSB  = CEN_BIT - 2;
    localparam int CINV_BIT  = CSEL_LSB - 1;
    localparam int WAIT_BIT  = CINV_BIT - 1;
    localparam int UF_W      = WAIT_BIT;

    localparam logic [2:0] SEQ_NEXT     = 3'd0;
    localparam logic [2:0] SEQ_JUMP     = 3'd1;
    localparam logic [2:0] SEQ_DISPATCH = 3'd2;
    localparam logic [2:0] SEQ_END      = 3'd3;
`ifdef USEQ_SUBROUTINE_EN
    localparam logic [2:0] SEQ_CALL     = 3'd4;
    localparam logic [2:0] SEQ_RET      = 3'd5;
`endif

    localparam logic [UADDR_W-1:0] FETCH_A = UADDR_W'(FETCH_UADDR);
    localparam logic [UADDR_W-1:0] DISP_A  = UADDR_W'(DISP_BASE);

    typedef enum logic [1:0] {
        ST_SETUP = 2'd0,
        ST_M     = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [UADDR_W-1:0]   r_uaddr;
    logic [UADDR_W-1:0]   w_uaddr_nx;

    // Decoded microword fields
    logic [CTRL_W-1:0]    w_ctrl_f;
    logic [UADDR_W-1:0]   w_naddr;
    logic [2:0]           w_seq;
    logic                 w_cond_en;
    logic [1:0]           w_cond_sel;
    logic                 w_cond_inv;
    logic                 w_wait;

    logic [OPC_W-1:0]     w_opcode;
    logic [UADDR_W-1:0]   w_disp_addr;
    logic [UADDR_W-1:0]   w_uaddr_inc;
    logic [UADDR_W-1:0]   w_target;
    logic                 w_taken;
    logic                 w_stall;
    logic                 w_final;
    logic                 w_halt_hit;

    assign w_ctrl_f   = i_ucode_data[UWORD_W-1 -: CTRL_W];
    assign w_naddr    = i_ucode_data[CTRL_LSB-1 -: UADDR_W];
    assign w_seq      = i_ucode_data[NADDR_LSB-1 -: 3];
    assign w_cond_en  = i_ucode_data[CEN_BIT];
    assign w_cond_sel = i_ucode_data[CEN_BIT-1 -: 2];
    assign w_cond_inv = i_ucode_data[CINV_BIT];
    assign w_wait     = i_ucode_data[WAIT_BIT];

    // Long opcodes carry a 1 in the MSB; short ones are zero-extended
    assign w_opcode    = i_instr[IW-1] ? i_instr[IW-2 -: OPC_W]
                                       : OPC_W'(i_instr[IW-2 -: SHORT_W]);
    assign w_disp_addr = DISP_A + UADDR_W'(w_opcode);
    assign w_uaddr_inc = r_uaddr + UADDR_W'(1);

    // A condition only gates JUMP/CALL; without cond_en the branch is unconditional
    assign w_taken = ~w_cond_en | (i_cond_in[w_cond_sel] ^ w_cond_inv);

    assign w_stall    = (r_state == ST_M) & w_wait & ~i_mem_ready;
    assign w_final    = (r_state == ST_M) & ~w_stall;
    assign w_halt_hit = (w_seq == SEQ_DISPATCH) && (i_instr == HALT_INSTR);

`ifdef USEQ_SUBROUTINE_EN
    logic [UADDR_W-1:0] r_ret;

    // Single-entry return address, captured when a taken CALL step completes
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ret <= '0;
        end else if (w_final && (w_seq == SEQ_CALL) && w_taken) begin
            r_ret <= w_uaddr_inc;
        end
    end
`endif

    // Next microaddress selected by the seq field of the current word
    always_comb begin
        w_target = w_uaddr_inc;
        case (w_seq)
            SEQ_NEXT:     w_target = w_uaddr_inc;
            SEQ_JUMP:     if (w_taken) w_target = w_naddr;
            SEQ_DISPATCH: w_target = w_disp_addr;
            SEQ_END:      w_target = FETCH_A;
`ifdef USEQ_SUBROUTINE_EN
            SEQ_CALL:     if (w_taken) w_target = w_naddr;
            SEQ_RET:      w_target = r_ret;
`endif
            default:      w_target = w_uaddr_inc;
        endcase
    end

    // State and microaddress registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_SETUP;
            r_uaddr <= FETCH_A;
        end else begin
            r_state <= w_state_nx;
            r_uaddr <= w_uaddr_nx;
        end
    end

    // Step sequencing: setup -> M (held while stalled) -> next step, or halt
    always_comb begin
        w_state_nx = r_state;
        w_uaddr_nx = r_uaddr;
        case (r_state)
            ST_SETUP: begin
                w_state_nx = ST_M;
            end
            ST_M: begin
                if (w_final) begin
                    if (w_halt_hit) begin
                        w_state_nx = ST_HALT;
                        w_uaddr_nx = FETCH_A;
                    end else begin
                        w_state_nx = ST_SETUP;
                        w_uaddr_nx = w_target;
                    end
                end
            end
            ST_HALT: begin
                w_uaddr_nx = FETCH_A;
                if (i_resume) begin
                    w_state_nx = ST_SETUP;
                end
            end
            default: begin
                w_state_nx = ST_SETUP;
                w_uaddr_nx = FETCH_A;
            end
        endcase
    end

    assign o_ucode_addr = r_uaddr;
    assign o_phase      = (r_state == ST_M);
    assign o_halted     = (r_state == ST_HALT);
    assign o_stall      = w_stall;
    // Strobes fire only on the completing M cycle, so each pulses once per step
    assign o_ctrl       = w_final ? w_ctrl_f : '0;
    assign o_ufield     = i_ucode_data[UF_W-1:0];

endmodule

// File: tb/tb_useq_decoder.sv
// tb/tb_useq_decoder.sv - self-checking bench for useq_decoder
module tb_useq_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] instr;
    logic [3:0]  cond_in;
    logic        mem_ready;
    logic        resume;

    logic [47:0] rom [256];

    logic [7:0]  addr;
    logic [47:0] data;
    logic [7:0]  ctrl;
    logic [23:0] ufield;
    logic        phase, stall, halted;

    logic [7:0]  d2_addr;
    logic [47:0] d2_data;
    logic [7:0]  d2_ctrl;
    logic [23:0] d2_ufield;
    logic        d2_phase, d2_stall, d2_halted;

    assign data    = rom[addr];
    assign d2_data = rom[d2_addr];

    useq_decoder dut (
        .i_clk(clk), .i_reset(reset), .i_instr(instr),
        .o_ucode_addr(addr), .i_ucode_data(data), .i_cond_in(cond_in),
        .i_mem_ready(mem_ready), .i_resume(resume),
        .o_ctrl(ctrl), .o_ufield(ufield), .o_phase(phase),
        .o_stall(stall), .o_halted(halted)
    );

    useq_decoder #(.DISP_BASE(64)) dut2 (
        .i_clk(clk), .i_reset(reset), .i_instr(instr),
        .o_ucode_addr(d2_addr), .i_ucode_data(d2_data), .i_cond_in(cond_in),
        .i_mem_ready(mem_ready), .i_resume(resume),
        .o_ctrl(d2_ctrl), .o_ufield(d2_ufield), .o_phase(d2_phase),
        .o_stall(d2_stall), .o_halted(d2_halted)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] mk(input logic [7:0] c, input logic [7:0] na,
                                       input logic [2:0] sq, input logic ce,
                                       input logic [1:0] cs, input logic ci,
                                       input logic wt, input logic [23:0] uf);
        return {c, na, sq, ce, cs, ci, wt, uf};
    endfunction

    task automatic init_rom();
        for (int i = 0; i < 256; i++) begin
            rom[i] = mk(8'(i + 1), 8'h00, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 24'(i * 3));
        end
    endtask

    // Reference model: one step = setup cycle + M cycle(s), address chosen by the seq rules
    logic [7:0] m_addr;
    logic       m_phase;
    logic       m_halted;
`ifdef USEQ_SUBROUTINE_EN
    logic [7:0] m_ret;
`endif

    function automatic logic [7:0] model_next(input logic [7:0] a, input logic [47:0] w,
                                              input logic [15:0] ins, input logic [3:0] c,
                                              input logic [7:0] ret);
        logic [2:0] sq;
        logic       ok;
        logic [7:0] opc;
        logic [7:0] r;
        sq  = w[31:29];
        ok  = !w[28] || (c[w[27:26]] ^ w[25]);
        opc = ins[15] ? {2'b00, ins[14:9]} : {6'b0, ins[14:13]};
        r   = a + 8'd1;
        if (sq == 3'd1 && ok) r = w[39:32];
        if (sq == 3'd2) r = opc;
        if (sq == 3'd3) r = 8'd2;
`ifdef USEQ_SUBROUTINE_EN
        if (sq == 3'd4 && ok) r = w[39:32];
        if (sq == 3'd5) r = ret;
`else
        if (ret == 8'hff && sq == 3'd7) r = a + 8'd1;
`endif
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_addr   <= 8'd2;
            m_phase  <= 1'b0;
            m_halted <= 1'b0;
`ifdef USEQ_SUBROUTINE_EN
            m_ret    <= 8'd0;
`endif
        end else if (m_halted) begin
            if (resume) m_halted <= 1'b0;
        end else if (!m_phase) begin
            m_phase <= 1'b1;
        end else if (rom[m_addr][24] && !mem_ready) begin
            m_phase <= 1'b1;
        end else begin
            m_phase <= 1'b0;
            if (rom[m_addr][31:29] == 3'd2 && instr == 16'hfe00) begin
                m_halted <= 1'b1;
                m_addr   <= 8'd2;
            end else begin
`ifdef USEQ_SUBROUTINE_EN
                m_addr <= model_next(m_addr, rom[m_addr], instr, cond_in, m_ret);
                if (rom[m_addr][31:29] == 3'd4 &&
                    (!rom[m_addr][28] || (cond_in[rom[m_addr][27:26]] ^ rom[m_addr][25])))
                    m_ret <= m_addr + 8'd1;
`else
                m_addr <= model_next(m_addr, rom[m_addr], instr, cond_in, 8'd0);
`endif
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (!reset) begin
            logic [47:0] w;
            logic        e_stall;
            logic [7:0]  e_ctrl;
            w       = rom[m_addr];
            e_stall = m_phase && w[24] && !mem_ready;
            e_ctrl  = (m_phase && !e_stall && !m_halted) ? w[47:40] : 8'h00;
            chk("cyc_addr",   48'(addr),   48'(m_addr));
            chk("cyc_phase",  48'(phase),  48'(m_phase));
            chk("cyc_halted", 48'(halted), 48'(m_halted));
            chk("cyc_stall",  48'(stall),  48'(e_stall));
            chk("cyc_ctrl",   48'(ctrl),   48'(e_ctrl));
            chk("cyc_ufield", 48'(ufield), 48'(w[23:0]));
        end
    end

    task automatic hold_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic release_reset();
        #1 reset = 1'b0;
    endtask

    task automatic wait_at(input string name, input logic [7:0] a, input logic ph, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (addr == a && phase == ph) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: timeout, addr %0h phase %0d, wanted addr %0h phase %0d",
                     name, addr, phase, a, ph);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] d_instr [2];
        logic [7:0]  d_exp1  [2];
        logic [7:0]  d_exp2  [2];
        reset = 1'b1; instr = 16'h0; cond_in = 4'h0; mem_ready = 1'b1; resume = 1'b0;
        init_rom();

        // Reset state
        @(negedge clk);
        chk("rst_addr",   48'(addr),   48'h2);
        chk("rst_phase",  48'(phase),  48'h0);
        chk("rst_ctrl",   48'(ctrl),   48'h0);
        chk("rst_stall",  48'(stall),  48'h0);
        chk("rst_halted", 48'(halted), 48'h0);

        // NEXT chain 2,3,4 with resume held high (must have no effect)
        resume = 1'b1;
        release_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("next_addr",  48'(addr),  48'(2 + (k + 1) / 2));
            chk("next_phase", 48'(phase), 48'((k % 2 == 0) ? 1 : 0));
            chk("next_ctrl",  48'(ctrl),  48'((k % 2 == 0) ? (3 + k / 2) : 0));
        end
        resume = 1'b0;

        // Wrap 255 -> 0
        hold_reset();
        init_rom();
        rom[2]   = mk(8'h12, 8'hff, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 24'h0);
        rom[255] = mk(8'hc3, 8'h00, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 24'h0);
        release_reset();
        wait_at("wrap_reach_ff", 8'hff, 1'b1, 20);
        chk("wrap_ctrl", 48'(ctrl), 48'hc3);
        @(negedge clk);
        chk("wrap_addr0", 48'(addr), 48'h0);

        // DISPATCH short/long opcodes, DISP_BASE 0 and 64
        d_instr[0] = 16'h4000; d_exp1[0] = 8'd2; d_exp2[0] = 8'd66;
        d_instr[1] = 16'h8600; d_exp1[1] = 8'd3; d_exp2[1] = 8'd67;
        for (int t = 0; t < 2; t++) begin
            hold_reset();
            init_rom();
            rom[2]    = mk(8'h12, 8'h10, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 24'h0);
            rom[8'h10] = mk(8'h5a, 8'h00, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 24'h0);
            instr = d_instr[t];
            release_reset();
            wait_at("disp_reach", 8'h10, 1'b1, 20);
            @(negedge clk);
            chk("disp_addr",  48'(addr),    48'(d_exp1[t]));
            chk("disp_addr2", 48'(d2_addr), 48'(d_exp2[t]));
        end
        instr = 16'h0;

        // Conditional jump on cond_in[1]
        for (int inv = 0; inv < 2; inv++) begin
            hold_reset();
            init_rom();
            rom[2] = mk(8'h21, 8'h40, 3'd1, 1'b1, 2'd1, inv[0], 1'b0, 24'h0);
            cond_in = 4'b0010;
            release_reset();
            wait_at("cond_reach", 8'h02, 1'b1, 10);
            @(negedge clk);
            chk("cond_addr", 48'(addr), 48'((inv == 0) ? 8'h40 : 8'h03));
        end
        cond_in = 4'h0;

        // Wait: three stalled cycles, then one strobe and advance
        hold_reset();
        init_rom();
        rom[2] = mk(8'h03, 8'h00, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 24'h0);
        mem_ready = 1'b0;
        release_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("wait_stall", 48'(stall), 48'h1);
            chk("wait_ctrl0", 48'(ctrl),  48'h0);
            chk("wait_hold",  48'(addr),  48'h2);
        end
        @(posedge clk);
        #1 mem_ready = 1'b1;
        @(negedge clk);
        chk("wait_release_stall", 48'(stall), 48'h0);
        chk("wait_pulse",         48'(ctrl),  48'h03);
        @(negedge clk);
        chk("wait_adv_addr",  48'(addr),  48'h3);
        chk("wait_adv_phase", 48'(phase), 48'h0);

        // Reset asserted mid-stall acts without a clock edge
        hold_reset();
        init_rom();
        rom[3] = mk(8'h04, 8'h00, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1, 24'h9);
        mem_ready = 1'b0;
        release_reset();
        wait_at("mid_reach", 8'h03, 1'b1, 20);
        chk("mid_stall", 48'(stall), 48'h1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_addr",  48'(addr),  48'h2);
        chk("mid_rst_phase", 48'(phase), 48'h0);
        chk("mid_rst_ctrl",  48'(ctrl),  48'h0);
        chk("mid_rst_stall", 48'(stall), 48'h0);
        init_rom();
        mem_ready = 1'b1;
        @(negedge clk);
        release_reset();
        @(negedge clk);
        chk("mid_first_phase", 48'(phase), 48'h1);
        chk("mid_first_ctrl",  48'(ctrl),  48'h03);

        // Halt on HALT_INSTR at DISPATCH, then resume
        hold_reset();
        init_rom();
        rom[2]     = mk(8'h12, 8'h10, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 24'h00abcd);
        rom[8'h10] = mk(8'h77, 8'h00, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 24'h0);
        instr = 16'hfe00;
        release_reset();
        wait_at("halt_reach", 8'h10, 1'b1, 20);
        chk("halt_last_ctrl", 48'(ctrl), 48'h77);
        @(negedge clk);
        chk("halt_flag",  48'(halted), 48'h1);
        chk("halt_addr",  48'(addr),   48'h2);
        chk("halt_phase", 48'(phase),  48'h0);
        chk("halt_ctrl",  48'(ctrl),   48'h0);
        chk("halt2_flag",   48'(d2_halted), 48'h1);
        chk("halt2_addr",   48'(d2_addr),   48'h2);
        chk("halt2_phase",  48'(d2_phase),  48'h0);
        chk("halt2_ctrl",   48'(d2_ctrl),   48'h0);
        chk("halt2_stall",  48'(d2_stall),  48'h0);
        chk("halt2_ufield", 48'(d2_ufield), 48'h00abcd);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("halt_stays", 48'(halted), 48'h1);
        end
        instr = 16'h0;
        @(posedge clk);
        #1 resume = 1'b1;
        @(posedge clk);
        #1 resume = 1'b0;
        @(negedge clk);
        chk("resume_flag",  48'(halted), 48'h0);
        chk("resume_addr",  48'(addr),   48'h2);
        chk("resume_phase", 48'(phase),  48'h0);
        @(negedge clk);
        chk("resume_ctrl", 48'(ctrl), 48'h12);

        // CALL / RET (CALL degrades to NEXT when subroutines are compiled out)
        hold_reset();
        init_rom();
        rom[2]     = mk(8'h12, 8'h10, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 24'h0);
        rom[8'h10] = mk(8'h44, 8'h80, 3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 24'h0);
        rom[8'h80] = mk(8'h45, 8'h00, 3'd5, 1'b0, 2'd0, 1'b0, 1'b0, 24'h0);
        release_reset();
        wait_at("call_reach", 8'h10, 1'b1, 20);
        @(negedge clk);
`ifdef USEQ_SUBROUTINE_EN
        chk("call_addr", 48'(addr), 48'h80);
        wait_at("ret_reach", 8'h80, 1'b1, 10);
        @(negedge clk);
        chk("ret_addr", 48'(addr), 48'h11);
`else
        chk("call_as_next", 48'(addr), 48'h11);
`endif
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
